// File: rtl/servo_ramp.sv
// servo_ramp: slew-rate limiter feeding the 8-bit duty input of the servo PDM stage.
// Accepts targets over valid/ready, walks duty toward the target by at most STEP
// counts every FRAME_DIV frame ticks, and buffers one pending target during a ramp.
// Optional build macro: SERVO_RAMP_CLAMP_EN clamps accepted targets to
// [MIN_DUTY, MAX_DUTY]; without it targets pass through untouched.
module servo_ramp #(
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  parameter int INIT_DUTY = 128,
  parameter int MIN_DUTY  = 0,
  parameter int MAX_DUTY  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hold,
  input  logic       tgt_valid,
  input  logic [7:0] tgt_data,
  output logic       tgt_ready,
  output logic [7:0] duty,
  output logic       busy,
  output logic       at_target
);

  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  RAMP     = 1'b1;
  localparam logic [7:0]  STEP_W   = 8'(STEP);
  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  // Parameter legality, caught at elaboration rather than as odd silicon behaviour.
  if (STEP < 1 || STEP > 255) begin : g_bad_step
    $error("servo_ramp: STEP must be 1..255");
  end
  if (FRAME_DIV < 1 || FRAME_DIV > 65535) begin : g_bad_div
    $error("servo_ramp: FRAME_DIV must be 1..65535");
  end
  if (MIN_DUTY < 0 || MAX_DUTY > 255 || INIT_DUTY < 0 || INIT_DUTY > 255) begin : g_bad_lim
    $error("servo_ramp: duty limits must be 8-bit values");
  end

`ifdef SERVO_RAMP_CLAMP_EN
  localparam logic [7:0] MIN_L = 8'(MIN_DUTY);
  localparam logic [7:0] MAX_L = 8'(MAX_DUTY);

  if (INIT_DUTY < MIN_DUTY || INIT_DUTY > MAX_DUTY) begin : g_bad_init
    $error("servo_ramp: INIT_DUTY outside [MIN_DUTY, MAX_DUTY]");
  end

  function automatic logic [7:0] clamp(input logic [7:0] v);
    if (v < MIN_L)      return MIN_L;
    else if (v > MAX_L) return MAX_L;
    else                return v;
  endfunction
`else
  function automatic logic [7:0] clamp(input logic [7:0] v);
    return v;
  endfunction
`endif

  logic [0:0]  state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [15:0] div_q, div_d;
  logic        at_q, at_d;

  logic              xfer;
  logic              complete;
  logic signed [8:0] diff;
  logic              going_up;
  logic [7:0]        mag;
  logic [7:0]        duty_step;

  assign tgt_ready = (state_q == IDLE) || !pend_valid_q;
  assign xfer      = tgt_valid && tgt_ready;
  assign complete  = (state_q == RAMP) && (duty_q == target_q);

  // One bounded step toward the target; landing exactly on it when closer than STEP.
  always_comb begin
    diff      = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
    going_up  = !diff[8];
    mag       = going_up ? diff[7:0] : (duty_q - target_q);
    duty_step = target_q;
    if (mag > STEP_W) begin
      duty_step = going_up ? (duty_q + STEP_W) : (duty_q - STEP_W);
    end
  end

  // Next-state: handshake, completion priority, and frame-divided updates.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    duty_d       = duty_q;
    target_d     = target_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    div_d        = div_q;
    at_d         = 1'b0;

    if (state_q == IDLE) begin
      if (xfer) begin
        target_d = clamp(tgt_data);
        div_d    = '0;
        state_d  = RAMP;
      end
    end else if (complete) begin
      at_d = 1'b1;
      if (pend_valid_q) begin
        target_d     = pend_q;
        pend_valid_d = 1'b0;
        div_d        = '0;
      end else if (xfer) begin
        target_d = clamp(tgt_data);
        div_d    = '0;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (xfer) begin
        pend_d       = clamp(tgt_data);
        pend_valid_d = 1'b1;
      end
      if (frame_tick && !hold) begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          duty_d = duty_step;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
    end
  end

  // State registers; reset drops both current and pending targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      duty_q       <= 8'(INIT_DUTY);
      target_q     <= 8'(INIT_DUTY);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      div_q        <= '0;
      at_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      div_q        <= div_d;
      at_q         <= at_d;
    end
  end

  assign duty      = duty_q;
  assign busy      = (state_q == RAMP);
  assign at_target = at_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed bench for servo_ramp: several parameterisations share one stimulus bus,
// each scenario resets and then checks the instance it targets.
module tb_servo_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       hold;
  logic       tgt_valid;
  logic [7:0] tgt_data;

  int n_vec = 0;
  int n_err = 0;

  logic       a_ready, a_busy, a_at;
  logic [7:0] a_duty;
  logic       b_ready, b_busy, b_at;
  logic [7:0] b_duty;
  logic       c_ready, c_busy, c_at;
  logic [7:0] c_duty;
  logic       d_ready, d_busy, d_at;
  logic [7:0] d_duty;

  always #5 clk = ~clk;

  servo_ramp #(.STEP(4), .FRAME_DIV(1)) u_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hold(hold),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(a_ready),
    .duty(a_duty), .busy(a_busy), .at_target(a_at));

  servo_ramp #(.STEP(4), .FRAME_DIV(3)) u_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hold(hold),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(b_ready),
    .duty(b_duty), .busy(b_busy), .at_target(b_at));

  servo_ramp #(.STEP(8), .FRAME_DIV(1)) u_c (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hold(hold),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(c_ready),
    .duty(c_duty), .busy(c_busy), .at_target(c_at));

  servo_ramp #(.STEP(2), .FRAME_DIV(1)) u_d (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hold(hold),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(d_ready),
    .duty(d_duty), .busy(d_busy), .at_target(d_at));

`ifdef SERVO_RAMP_CLAMP_EN
  logic       e_ready, e_busy, e_at;
  logic [7:0] e_duty;

  servo_ramp #(.STEP(255), .FRAME_DIV(1), .INIT_DUTY(128), .MIN_DUTY(20), .MAX_DUTY(230)) u_e (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .hold(hold),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(e_ready),
    .duty(e_duty), .busy(e_busy), .at_target(e_at));
`endif

  // Inputs change right after a falling edge; outputs are read at falling edges.
  task automatic do_reset();
    rst = 1'b1; frame_tick = 1'b0; hold = 1'b0; tgt_valid = 1'b0; tgt_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tgt_valid = 1'b1; tgt_data = d;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (a_duty !== 8'd128) begin n_err++; $display("FAIL rst_duty got %0d want 128", a_duty); end
    n_vec++; if (a_busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy got %b want 0", a_busy); end
    n_vec++; if (a_ready !== 1'b1)  begin n_err++; $display("FAIL rst_ready got %b want 1", a_ready); end
    n_vec++; if (a_at !== 1'b0)     begin n_err++; $display("FAIL rst_at got %b want 0", a_at); end
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp_duty;
    do_reset();
    send(8'd140);
    n_vec++; if (a_busy !== 1'b1)   begin n_err++; $display("FAIL up_busy got %b want 1", a_busy); end
    n_vec++; if (a_duty !== 8'd128) begin n_err++; $display("FAIL up_t0 duty got %0d want 128", a_duty); end
    for (int k = 1; k <= 3; k++) begin
      pulse_tick();
      exp_duty = 8'(128 + 4 * k);
      n_vec++; if (a_duty !== exp_duty) begin n_err++; $display("FAIL up_t%0d duty got %0d want %0d", k, a_duty, exp_duty); end
    end
    n_vec++; if (a_at !== 1'b0 || a_busy !== 1'b1) begin n_err++; $display("FAIL up_cmpl at/busy got %b/%b want 0/1", a_at, a_busy); end
    @(negedge clk);
    n_vec++; if (a_at !== 1'b1 || a_busy !== 1'b0) begin n_err++; $display("FAIL up_done at/busy got %b/%b want 1/0", a_at, a_busy); end
    @(negedge clk);
    n_vec++; if (a_at !== 1'b0) begin n_err++; $display("FAIL up_pulse at got %b want 0", a_at); end
  endtask

  task automatic test_frame_div();
    do_reset();
    n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL div_ready got %b want 1", b_ready); end
    send(8'd130);
    pulse_tick();
    n_vec++; if (b_duty !== 8'd128) begin n_err++; $display("FAIL div_t1 duty got %0d want 128", b_duty); end
    pulse_tick();
    n_vec++; if (b_duty !== 8'd128) begin n_err++; $display("FAIL div_t2 duty got %0d want 128", b_duty); end
    pulse_tick();
    n_vec++; if (b_duty !== 8'd130) begin n_err++; $display("FAIL div_t3 duty got %0d want 130", b_duty); end
    @(negedge clk);
    n_vec++; if (b_at !== 1'b1 || b_busy !== 1'b0) begin n_err++; $display("FAIL div_done at/busy got %b/%b want 1/0", b_at, b_busy); end
    send(8'd130);
    n_vec++; if (b_busy !== 1'b1 || b_at !== 1'b0) begin n_err++; $display("FAIL same_cmpl busy/at got %b/%b want 1/0", b_busy, b_at); end
    @(negedge clk);
    n_vec++; if (b_at !== 1'b1 || b_busy !== 1'b0 || b_duty !== 8'd130) begin
      n_err++; $display("FAIL same_done at/busy/duty got %b/%b/%0d want 1/0/130", b_at, b_busy, b_duty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_duty;
    do_reset();
    send(8'd200);
    pulse_tick();
    pulse_tick();
    n_vec++; if (c_duty !== 8'd144 || c_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_pre duty/ready got %0d/%b want 144/1", c_duty, c_ready); end
    send(8'd100);
    n_vec++; if (c_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full ready got %b want 0", c_ready); end
    tgt_valid = 1'b1; tgt_data = 8'd50; frame_tick = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_vec++; if (c_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall%0d ready got %b want 0", k, c_ready); end
    end
    frame_tick = 1'b0;
    n_vec++; if (c_duty !== 8'd200) begin n_err++; $display("FAIL b2b_reach duty got %0d want 200", c_duty); end
    @(negedge clk);
    n_vec++; if (c_at !== 1'b1 || c_busy !== 1'b1 || c_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_swap at/busy/ready got %b/%b/%b want 1/1/1", c_at, c_busy, c_ready); end
    @(negedge clk);
    tgt_valid = 1'b0;
    n_vec++; if (c_ready !== 1'b0 || c_at !== 1'b0) begin
      n_err++; $display("FAIL b2b_accept3 ready/at got %b/%b want 0/0", c_ready, c_at); end
    frame_tick = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_duty = (200 - 8 * k < 100) ? 8'd100 : 8'(200 - 8 * k);
      n_vec++; if (c_duty !== exp_duty) begin n_err++; $display("FAIL b2b_down%0d duty got %0d want %0d", k, c_duty, exp_duty); end
    end
    frame_tick = 1'b0;
    @(negedge clk);
    n_vec++; if (c_at !== 1'b1 || c_busy !== 1'b1 || c_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_swap2 at/busy/ready got %b/%b/%b want 1/1/1", c_at, c_busy, c_ready); end
    pulse_tick();
    n_vec++; if (c_duty !== 8'd92) begin n_err++; $display("FAIL b2b_to50 duty got %0d want 92", c_duty); end
  endtask

  task automatic test_hold();
    do_reset();
    send(8'd200);
    pulse_tick();
    pulse_tick();
    n_vec++; if (d_duty !== 8'd132) begin n_err++; $display("FAIL hold_pre duty got %0d want 132", d_duty); end
    hold = 1'b1; frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    tgt_valid = 1'b1; tgt_data = 8'd150;
    @(negedge clk);
    tgt_valid = 1'b0;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    n_vec++; if (d_duty !== 8'd132) begin n_err++; $display("FAIL hold_frozen duty got %0d want 132", d_duty); end
    n_vec++; if (d_ready !== 1'b0 || d_busy !== 1'b1 || d_at !== 1'b0) begin
      n_err++; $display("FAIL hold_pend ready/busy/at got %b/%b/%b want 0/1/0", d_ready, d_busy, d_at); end
    hold = 1'b0;
    pulse_tick();
    n_vec++; if (d_duty !== 8'd134) begin n_err++; $display("FAIL hold_resume duty got %0d want 134", d_duty); end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    send(8'd250);
    pulse_tick();
    pulse_tick();
    send(8'd100);
    pulse_tick();
    n_vec++; if (c_duty !== 8'd152 || c_busy !== 1'b1 || c_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_pre duty/busy/ready got %0d/%b/%b want 152/1/0", c_duty, c_busy, c_ready); end
    rst = 1'b1;
    #1;
    n_vec++; if (c_duty !== 8'd128 || c_busy !== 1'b0 || c_ready !== 1'b1 || c_at !== 1'b0) begin
      n_err++; $display("FAIL mid_rst duty/busy/ready/at got %0d/%b/%b/%b want 128/0/1/0", c_duty, c_busy, c_ready, c_at); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_tick();
    n_vec++; if (c_duty !== 8'd128 || c_busy !== 1'b0 || c_at !== 1'b0) begin
      n_err++; $display("FAIL mid_after duty/busy/at got %0d/%b/%b want 128/0/0", c_duty, c_busy, c_at); end
  endtask

`ifdef SERVO_RAMP_CLAMP_EN
  task automatic test_clamp();
    do_reset();
    send(8'd250);
    pulse_tick();
    n_vec++; if (e_duty !== 8'd230) begin n_err++; $display("FAIL clamp_hi duty got %0d want 230", e_duty); end
    @(negedge clk);
    n_vec++; if (e_at !== 1'b1 || e_busy !== 1'b0 || e_ready !== 1'b1) begin
      n_err++; $display("FAIL clamp_done at/busy/ready got %b/%b/%b want 1/0/1", e_at, e_busy, e_ready); end
    send(8'd5);
    pulse_tick();
    n_vec++; if (e_duty !== 8'd20) begin n_err++; $display("FAIL clamp_lo duty got %0d want 20", e_duty); end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_up();
    test_frame_div();
    test_back_to_back();
    test_hold();
    test_reset_mid_ramp();
`ifdef SERVO_RAMP_CLAMP_EN
    test_clamp();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
